// File: rtl/apb_master_param_if.sv
// Bundle of the upstream request/response handshake and the APB4 bus for apb_master_param.
// The master modport is the requester's view; the slave modport is everything on the far side.
interface apb_master_param_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int NSLV   = 4
);
   localparam int STRB_W = DATA_W / 8;

   logic                     req_valid;
   logic                     req_ready;
   logic                     req_write;
   logic [ADDR_W-1:0]        req_addr;
   logic [DATA_W-1:0]        req_wdata;
   logic [STRB_W-1:0]        req_strb;
   logic [2:0]               req_prot;

   logic                     rsp_valid;
   logic [DATA_W-1:0]        rsp_rdata;
   logic                     rsp_err;
   logic                     rsp_timeout;

   logic [ADDR_W-1:0]        PADDR;
   logic [2:0]               PPROT;
   logic [NSLV-1:0]          PSEL;
   logic                     PENABLE;
   logic                     PWRITE;
   logic [DATA_W-1:0]        PWDATA;
   logic [STRB_W-1:0]        PSTRB;
   logic [NSLV-1:0]          PREADY;
   logic [NSLV*DATA_W-1:0]   PRDATA;
   logic [NSLV-1:0]          PSLVERR;

   logic [1:0]               Out_State;

   modport master (
      input  req_valid, req_write, req_addr, req_wdata, req_strb, req_prot,
      input  PREADY, PRDATA, PSLVERR,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
      output PADDR, PPROT, PSEL, PENABLE, PWRITE, PWDATA, PSTRB, Out_State
   );

   modport slave (
      output req_valid, req_write, req_addr, req_wdata, req_strb, req_prot,
      output PREADY, PRDATA, PSLVERR,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
      input  PADDR, PPROT, PSEL, PENABLE, PWRITE, PWDATA, PSTRB, Out_State
   );
endinterface

// File: rtl/apb_master_param.sv
// Parametrised APB4 requester: registers upstream requests, decodes a slave select
// from an address field and runs Idle/Setup/Access with decode-error and timeout handling.
module apb_master_param #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int NSLV    = 4,
   parameter int SEL_LSB = 12,
   parameter int TIMEOUT = 16
) (
   input logic                PCLK,
   input logic                PRESETn,
   apb_master_param_if.master bus
);
   localparam int STRB_W = DATA_W / 8;
   localparam int IDX_W  = (NSLV > 1) ? $clog2(NSLV) : 1;
   localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [IDX_W:0]   NSLV_V   = (IDX_W + 1)'(NSLV);
   localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_t;

   state_t              state_q;
   logic [ADDR_W-1:0]   paddr_q;
   logic [DATA_W-1:0]   pwdata_q;
   logic [STRB_W-1:0]   pstrb_q;
   logic [2:0]          pprot_q;
   logic                pwrite_q;
   logic [IDX_W-1:0]    idx_q;
   logic [CNT_W-1:0]    cnt_q;
   logic                rspValid_q;
   logic                rspErr_q;
   logic                rspTimeout_q;
   logic [DATA_W-1:0]   rspRdata_q;

   logic [IDX_W-1:0]    idx_d;
   logic                selReady;
   logic                selErr;
   logic [DATA_W-1:0]   selRdata;
   logic                inAccess;
   logic                decErr;
   logic                timeoutHit;
   logic                done;
   logic                accept;

   always_comb begin
      idx_d = '0;
      if (NSLV > 1)
         idx_d = bus.req_addr[SEL_LSB +: IDX_W];
   end

   // Only the registered slave's PREADY/PSLVERR/PRDATA are ever looked at.
   always_comb begin
      selReady = 1'b0;
      selErr   = 1'b0;
      selRdata = '0;
      for (int i = 0; i < NSLV; i++) begin
         if (idx_q == IDX_W'(i)) begin
            selReady = bus.PREADY[i];
            selErr   = bus.PSLVERR[i];
            selRdata = bus.PRDATA[i*DATA_W +: DATA_W];
         end
      end
   end

   assign inAccess   = (state_q == ACCESS);
   assign decErr     = ({1'b0, idx_q} >= NSLV_V);
   assign timeoutHit = (TIMEOUT != 0) && inAccess && !selReady && !decErr && (cnt_q == CNT_LAST);
   assign done       = inAccess && (selReady || decErr || timeoutHit);
   assign accept     = bus.req_valid && bus.req_ready;

   assign bus.req_ready   = (state_q == IDLE) || done;
   assign bus.PENABLE     = inAccess;
   assign bus.PADDR       = paddr_q;
   assign bus.PWRITE      = pwrite_q;
   assign bus.PWDATA      = pwdata_q;
   assign bus.PSTRB       = pstrb_q;
   assign bus.PPROT       = pprot_q;
   assign bus.Out_State   = state_q;
   assign bus.rsp_valid   = rspValid_q;
   assign bus.rsp_rdata   = rspRdata_q;
   assign bus.rsp_err     = rspErr_q;
   assign bus.rsp_timeout = rspTimeout_q;

   // An out-of-range index leaves every select low.
   always_comb begin
      bus.PSEL = '0;
      if (state_q == SETUP || state_q == ACCESS) begin
         for (int i = 0; i < NSLV; i++) begin
            if (idx_q == IDX_W'(i))
               bus.PSEL[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q      <= IDLE;
         paddr_q      <= '0;
         pwdata_q     <= '0;
         pstrb_q      <= '0;
         pprot_q      <= '0;
         pwrite_q     <= 1'b0;
         idx_q        <= '0;
         cnt_q        <= '0;
         rspValid_q   <= 1'b0;
         rspErr_q     <= 1'b0;
         rspTimeout_q <= 1'b0;
         rspRdata_q   <= '0;
      end else begin
         rspValid_q <= 1'b0;

         if (accept) begin
            paddr_q  <= bus.req_addr;
            pwdata_q <= bus.req_wdata;
            pstrb_q  <= bus.req_write ? bus.req_strb : '0;
            pprot_q  <= bus.req_prot;
            pwrite_q <= bus.req_write;
            idx_q    <= idx_d;
         end

         // Counter saturates at TIMEOUT so a long stall can never wrap it.
         if (state_q == SETUP)
            cnt_q <= '0;
         else if (inAccess && cnt_q != CNT_MAX)
            cnt_q <= cnt_q + 1'b1;

         if (done) begin
            rspValid_q   <= 1'b1;
            rspErr_q     <= decErr || timeoutHit || (selReady && selErr);
            rspTimeout_q <= timeoutHit;
            rspRdata_q   <= (!pwrite_q && selReady && !selErr) ? selRdata : '0;
         end

         case (state_q)
            IDLE:    if (accept) state_q <= SETUP;
            SETUP:   state_q <= ACCESS;
            ACCESS:  if (done) state_q <= bus.req_valid ? SETUP : IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_apb_master_param.sv
// Directed bench for apb_master_param: a 4-slave instance with TIMEOUT=4 and a
// 3-slave instance with no timeout for the decode-error case.
module tb_apb_master_param;
   logic PCLK = 1'b0;
   logic PRESETn;
   int   vectors     = 0;
   int   miscompares = 0;

   localparam logic [31:0] S0 = 32'h1111_0000;
   localparam logic [31:0] S1 = 32'h1234_5678;
   localparam logic [31:0] S2 = 32'h2222_0000;
   localparam logic [31:0] S3 = 32'h3333_0000;
   localparam logic [31:0] B2B_ADDR [3] = '{32'h0000_0000, 32'h0000_3000, 32'h0000_2000};
   localparam logic [31:0] B2B_DATA [3] = '{S0, S3, S2};

   apb_master_param_if #(.ADDR_W(32), .DATA_W(32), .NSLV(4)) bus ();
   apb_master_param_if #(.ADDR_W(32), .DATA_W(32), .NSLV(3)) bus3 ();

   apb_master_param #(.ADDR_W(32), .DATA_W(32), .NSLV(4), .SEL_LSB(12), .TIMEOUT(4)) dut (
      .PCLK(PCLK), .PRESETn(PRESETn), .bus(bus)
   );

   apb_master_param #(.ADDR_W(32), .DATA_W(32), .NSLV(3), .SEL_LSB(12), .TIMEOUT(0)) dut3 (
      .PCLK(PCLK), .PRESETn(PRESETn), .bus(bus3)
   );

   always #5 PCLK = ~PCLK;

   task automatic tick();
      @(posedge PCLK);
      #1;
   endtask

   task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] strb, input logic [2:0] prot);
      bus.req_valid = 1'b1;
      bus.req_write = wr;
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
      bus.req_strb  = strb;
      bus.req_prot  = prot;
   endtask

   task automatic idleRequest();
      bus.req_valid = 1'b0;
   endtask

   task automatic test_reset();
      PRESETn = 1'b0;
      applyStimulus(1'b1, 32'h2004, 32'hCAFE_F00D, 4'hF, 3'b111);
      #1;
      vectors++;
      if (bus.Out_State !== 2'd0) begin miscompares++; $display("[TB] FAIL reset_state: got %0d expected 0", bus.Out_State); end
      vectors++;
      if ({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PSTRB, bus.PPROT} !== 13'd0) begin
         miscompares++; $display("[TB] FAIL reset_apb_ctrl: got %h expected 0", {bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PSTRB, bus.PPROT});
      end
      vectors++;
      if ({bus.rsp_valid, bus.rsp_err, bus.rsp_timeout, bus.rsp_rdata} !== 35'd0) begin
         miscompares++; $display("[TB] FAIL reset_rsp: got %h expected 0", {bus.rsp_valid, bus.rsp_err, bus.rsp_timeout, bus.rsp_rdata});
      end
      vectors++;
      if (bus.req_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_req_ready: got %b expected 1", bus.req_ready); end
      tick();
      tick();
      vectors++;
      if (bus.Out_State !== 2'd0 || bus.PADDR !== 32'd0 || bus.PWDATA !== 32'd0) begin
         miscompares++; $display("[TB] FAIL reset_ignores_req: got state %0d paddr %h expected 0/0", bus.Out_State, bus.PADDR);
      end
      idleRequest();
      @(negedge PCLK);
      PRESETn = 1'b1;
      tick();
   endtask

   task automatic test_zero_wait_write();
      applyStimulus(1'b1, 32'h2004, 32'hDEAD_BEEF, 4'hF, 3'b010);
      tick();
      idleRequest();
      vectors++;
      if (bus.Out_State !== 2'd1 || bus.PSEL !== 4'b0100 || bus.PENABLE !== 1'b0) begin
         miscompares++; $display("[TB] FAIL wr_setup: got state %0d psel %b pen %b expected 1 0100 0", bus.Out_State, bus.PSEL, bus.PENABLE);
      end
      vectors++;
      if (bus.PADDR !== 32'h2004 || bus.PWDATA !== 32'hDEAD_BEEF || bus.PWRITE !== 1'b1 || bus.PSTRB !== 4'hF || bus.PPROT !== 3'b010) begin
         miscompares++; $display("[TB] FAIL wr_bus_fields: got %h %h %b %h %b expected 2004 deadbeef 1 f 010",
                                 bus.PADDR, bus.PWDATA, bus.PWRITE, bus.PSTRB, bus.PPROT);
      end
      tick();
      vectors++;
      if (bus.Out_State !== 2'd2 || bus.PSEL !== 4'b0100 || bus.PENABLE !== 1'b1 || bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
         miscompares++; $display("[TB] FAIL wr_access: got state %0d psel %b pen %b rdy %b rv %b expected 2 0100 1 1 0",
                                 bus.Out_State, bus.PSEL, bus.PENABLE, bus.req_ready, bus.rsp_valid);
      end
      tick();
      vectors++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b0 || bus.rsp_rdata !== 32'd0 || bus.Out_State !== 2'd0 || bus.PSEL !== 4'd0) begin
         miscompares++; $display("[TB] FAIL wr_rsp: got rv %b err %b rdata %h state %0d psel %b expected 1 0 0 0 0",
                                 bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, bus.Out_State, bus.PSEL);
      end
      tick();
      vectors++;
      if (bus.rsp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL wr_rsp_pulse: got %b expected 0", bus.rsp_valid); end
   endtask

   task automatic test_wait_read();
      applyStimulus(1'b0, 32'h1000, 32'hFFFF_FFFF, 4'hF, 3'b000);
      tick();
      idleRequest();
      bus.PREADY = 4'b1101;
      vectors++;
      if (bus.PSEL !== 4'b0010 || bus.PSTRB !== 4'h0 || bus.PWRITE !== 1'b0) begin
         miscompares++; $display("[TB] FAIL rd_setup: got psel %b pstrb %h pwrite %b expected 0010 0 0", bus.PSEL, bus.PSTRB, bus.PWRITE);
      end
      for (int k = 0; k < 3; k++) begin
         tick();
         vectors++;
         if (bus.PENABLE !== 1'b1 || bus.PADDR !== 32'h1000 || bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b0) begin
            miscompares++; $display("[TB] FAIL rd_wait%0d: got pen %b paddr %h rdy %b rv %b expected 1 1000 0 0",
                                    k, bus.PENABLE, bus.PADDR, bus.req_ready, bus.rsp_valid);
         end
      end
      tick();
      bus.PREADY = 4'hF;
      #1;
      vectors++;
      if (bus.PENABLE !== 1'b1 || bus.PADDR !== 32'h1000 || bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
         miscompares++; $display("[TB] FAIL rd_last_access: got pen %b paddr %h rdy %b rv %b expected 1 1000 1 0",
                                 bus.PENABLE, bus.PADDR, bus.req_ready, bus.rsp_valid);
      end
      tick();
      vectors++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== S1 || bus.rsp_err !== 1'b0 || bus.rsp_timeout !== 1'b0) begin
         miscompares++; $display("[TB] FAIL rd_rsp: got rv %b rdata %h err %b to %b expected 1 %h 0 0",
                                 bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout, S1);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      int   reqIdx;
      int   rspIdx;
      logic hs;
      logic [1:0] expState;
      logic expValid;
      reqIdx = 0;
      rspIdx = 0;
      bus.PSLVERR = 4'b0010;
      applyStimulus(1'b0, B2B_ADDR[0], 32'd0, 4'h0, 3'b000);
      for (int c = 0; c < 7; c++) begin
         hs = bus.req_valid && bus.req_ready;
         tick();
         if (hs) begin
            reqIdx++;
            if (reqIdx < 3) applyStimulus(1'b0, B2B_ADDR[reqIdx], 32'd0, 4'h0, 3'b000);
            else idleRequest();
         end
         expState = (c == 6) ? 2'd0 : ((c % 2 == 0) ? 2'd1 : 2'd2);
         expValid = (c >= 2) && (c % 2 == 0);
         vectors++;
         if (bus.Out_State !== expState || bus.rsp_valid !== expValid) begin
            miscompares++; $display("[TB] FAIL b2b_cycle%0d: got state %0d rv %b expected %0d %b",
                                    c, bus.Out_State, bus.rsp_valid, expState, expValid);
         end
         if (expValid) begin
            vectors++;
            if (bus.rsp_rdata !== B2B_DATA[rspIdx] || bus.rsp_err !== 1'b0) begin
               miscompares++; $display("[TB] FAIL b2b_rsp%0d: got rdata %h err %b expected %h 0",
                                       rspIdx, bus.rsp_rdata, bus.rsp_err, B2B_DATA[rspIdx]);
            end
            rspIdx++;
         end
      end
      bus.PSLVERR = 4'b0000;
      tick();
   endtask

   task automatic test_slave_error();
      bus.PSLVERR = 4'b0100;
      applyStimulus(1'b0, 32'h2000, 32'd0, 4'h0, 3'b000);
      tick();
      idleRequest();
      tick();
      tick();
      vectors++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b1 || bus.rsp_rdata !== 32'd0 || bus.rsp_timeout !== 1'b0) begin
         miscompares++; $display("[TB] FAIL slverr_rsp: got rv %b err %b rdata %h to %b expected 1 1 0 0",
                                 bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, bus.rsp_timeout);
      end
      bus.PSLVERR = 4'b0000;
      tick();
   endtask

   task automatic test_decode_error();
      bus3.req_valid = 1'b1;
      bus3.req_write = 1'b0;
      bus3.req_addr  = 32'h3000;
      #1;
      vectors++;
      if (bus3.req_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL dec_ready_idle: got %b expected 1", bus3.req_ready); end
      tick();
      bus3.req_valid = 1'b0;
      vectors++;
      if (bus3.PSEL !== 3'b000 || bus3.Out_State !== 2'd1) begin
         miscompares++; $display("[TB] FAIL dec_setup: got psel %b state %0d expected 000 1", bus3.PSEL, bus3.Out_State);
      end
      tick();
      vectors++;
      if (bus3.PSEL !== 3'b000 || bus3.PENABLE !== 1'b1 || bus3.req_ready !== 1'b1) begin
         miscompares++; $display("[TB] FAIL dec_access: got psel %b pen %b rdy %b expected 000 1 1", bus3.PSEL, bus3.PENABLE, bus3.req_ready);
      end
      tick();
      vectors++;
      if (bus3.rsp_valid !== 1'b1 || bus3.rsp_err !== 1'b1 || bus3.rsp_rdata !== 32'd0 || bus3.rsp_timeout !== 1'b0 || bus3.Out_State !== 2'd0) begin
         miscompares++; $display("[TB] FAIL dec_rsp: got rv %b err %b rdata %h to %b state %0d expected 1 1 0 0 0",
                                 bus3.rsp_valid, bus3.rsp_err, bus3.rsp_rdata, bus3.rsp_timeout, bus3.Out_State);
      end
   endtask

   task automatic test_timeout();
      applyStimulus(1'b0, 32'h1000, 32'd0, 4'h0, 3'b000);
      tick();
      idleRequest();
      bus.PREADY = 4'b1101;
      for (int k = 0; k < 4; k++) begin
         tick();
         vectors++;
         if (bus.PENABLE !== 1'b1 || bus.Out_State !== 2'd2 || bus.req_ready !== (k == 3)) begin
            miscompares++; $display("[TB] FAIL to_access%0d: got pen %b state %0d rdy %b expected 1 2 %b",
                                    k, bus.PENABLE, bus.Out_State, bus.req_ready, (k == 3));
         end
      end
      tick();
      vectors++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b1 || bus.rsp_timeout !== 1'b1 || bus.rsp_rdata !== 32'd0
          || bus.Out_State !== 2'd0 || bus.PENABLE !== 1'b0) begin
         miscompares++; $display("[TB] FAIL to_rsp: got rv %b err %b to %b rdata %h state %0d pen %b expected 1 1 1 0 0 0",
                                 bus.rsp_valid, bus.rsp_err, bus.rsp_timeout, bus.rsp_rdata, bus.Out_State, bus.PENABLE);
      end
      bus.PREADY = 4'hF;
      tick();
   endtask

   task automatic test_reset_mid_access();
      bus.PREADY = 4'b1101;
      applyStimulus(1'b0, 32'h1000, 32'd0, 4'h0, 3'b000);
      tick();
      idleRequest();
      tick();
      tick();
      #2;
      PRESETn = 1'b0;
      #1;
      vectors++;
      if (bus.PSEL !== 4'd0 || bus.PENABLE !== 1'b0 || bus.Out_State !== 2'd0) begin
         miscompares++; $display("[TB] FAIL rst_async: got psel %b pen %b state %0d expected 0 0 0", bus.PSEL, bus.PENABLE, bus.Out_State);
      end
      tick();
      @(negedge PCLK);
      PRESETn = 1'b1;
      bus.PREADY = 4'hF;
      tick();
      vectors++;
      if (bus.rsp_valid !== 1'b0 || bus.Out_State !== 2'd0) begin
         miscompares++; $display("[TB] FAIL rst_no_rsp: got rv %b state %0d expected 0 0", bus.rsp_valid, bus.Out_State);
      end
      applyStimulus(1'b0, 32'h3004, 32'd0, 4'h0, 3'b000);
      tick();
      idleRequest();
      tick();
      tick();
      vectors++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== S3 || bus.rsp_err !== 1'b0 || bus.PADDR !== 32'h3004) begin
         miscompares++; $display("[TB] FAIL rst_recover: got rv %b rdata %h err %b paddr %h expected 1 %h 0 3004",
                                 bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.PADDR, S3);
      end
      tick();
   endtask

   initial begin
      bus.req_valid  = 1'b0;
      bus.req_write  = 1'b0;
      bus.req_addr   = '0;
      bus.req_wdata  = '0;
      bus.req_strb   = '0;
      bus.req_prot   = '0;
      bus.PREADY     = 4'hF;
      bus.PSLVERR    = 4'h0;
      bus.PRDATA     = {S3, S2, S1, S0};
      bus3.req_valid = 1'b0;
      bus3.req_write = 1'b0;
      bus3.req_addr  = '0;
      bus3.req_wdata = '0;
      bus3.req_strb  = '0;
      bus3.req_prot  = '0;
      bus3.PREADY    = 3'b000;
      bus3.PSLVERR   = 3'b000;
      bus3.PRDATA    = {S2, S1, S0};

      test_reset();
      test_zero_wait_write();
      test_wait_read();
      test_back_to_back();
      test_slave_error();
      test_decode_error();
      test_timeout();
      test_reset_mid_access();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
